// File: rtl/thor2022_gshare_predictor_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : thor2022_gshare_predictor_pkg
// Description : Shared types and constants for the Thor2022 global-history
//               branch direction predictor (address type, 2-bit counter type,
//               counter encodings, init-sweep FSM state encodings).
// Revision    : 1.0 - initial release
// ============================================================================
package thor2022_gshare_predictor_pkg;

    typedef logic [31:0] Address;

    // 2-bit saturating direction counter; bit 1 is the predicted direction.
    typedef logic [1:0] bp_ctr_t;

    localparam bp_ctr_t BP_STRONG_NT = 2'd0;
    localparam bp_ctr_t BP_WEAK_NT   = 2'd1;
    localparam bp_ctr_t BP_WEAK_T    = 2'd2;
    localparam bp_ctr_t BP_STRONG_T  = 2'd3;

    // Init-sweep state machine encoding.
    typedef logic [0:0] bp_state_t;

    localparam bp_state_t c_st_init = 1'b0;
    localparam bp_state_t c_st_run  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/thor2022_gshare_predictor_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : thor2022_gshare_predictor_if
// Description : Fetch/commit bus of the branch predictor.
//               Fetch side  : en, ip, ibranch -> predict_taken, busy
//               Commit side : x0_* / x1_* in-order retire slots
//               Debug       : ghist_spec_o speculative history
//               master = pipeline side, slave = predictor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface thor2022_gshare_predictor_if #(
    parameter int HIST_BITS = 6
);
    import thor2022_gshare_predictor_pkg::*;

    logic                 en;
    Address               ip;
    logic                 ibranch;
    logic                 predict_taken;
    logic                 busy;
    logic                 x0_valid;
    Address               x0_ip;
    logic                 x0_takb;
    logic                 x0_mispredict;
    logic                 x1_valid;
    Address               x1_ip;
    logic                 x1_takb;
    logic                 x1_mispredict;
    logic [HIST_BITS-1:0] ghist_spec_o;

    modport master (
        output en, ip, ibranch,
        output x0_valid, x0_ip, x0_takb, x0_mispredict,
        output x1_valid, x1_ip, x1_takb, x1_mispredict,
        input  predict_taken, busy, ghist_spec_o
    );

    modport slave (
        input  en, ip, ibranch,
        input  x0_valid, x0_ip, x0_takb, x0_mispredict,
        input  x1_valid, x1_ip, x1_takb, x1_mispredict,
        output predict_taken, busy, ghist_spec_o
    );

endinterface
`default_nettype wire

// File: rtl/thor2022_bp_ctr_update.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : thor2022_bp_ctr_update
// Description : Combinational 2-bit saturating counter update.
//               i_ctr  : current counter
//               i_takb : actual branch outcome
//               o_ctr  : counter after the update (+1 capped at 3 / -1 floored at 0)
// Revision    : 1.0 - initial release
// ============================================================================
module thor2022_bp_ctr_update
    import thor2022_gshare_predictor_pkg::*;
(
    input  bp_ctr_t i_ctr,
    input  logic    i_takb,
    output bp_ctr_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_takb) begin
            if (i_ctr != BP_STRONG_T) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != BP_STRONG_NT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/thor2022_gshare_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : thor2022_gshare_predictor
// Description : Global-history branch direction predictor with a table of
//               2^TBL_BITS 2-bit counters, gselect (MODE=0) or gshare (MODE=1)
//               indexing, two in-order commit update slots, a speculative
//               history repaired on mispredict, and a post-reset init sweep.
//   clk, rst : clock, synchronous active-high reset
//   bp       : fetch/commit bus (slave side), see thor2022_gshare_predictor_if
// Revision    : 1.0 - initial release
// ============================================================================
module thor2022_gshare_predictor
    import thor2022_gshare_predictor_pkg::*;
#(
    parameter int      TBL_BITS  = 10,
    parameter int      HIST_BITS = 6,
    parameter int      MODE      = 1,
    parameter bp_ctr_t INIT_CTR  = BP_WEAK_T
) (
    input  logic clk,
    input  logic rst,
    thor2022_gshare_predictor_if.slave bp
);

    localparam int c_entries = 1 << TBL_BITS;

    bp_state_t            state_q, state_d;
    logic [TBL_BITS-1:0]  sweep_q, sweep_d;
    logic [HIST_BITS-1:0] ghist_spec_q, ghist_spec_d;
    logic [HIST_BITS-1:0] ghist_arch_q, ghist_arch_d;
    logic [HIST_BITS-1:0] ghist_arch_mid;
    bp_ctr_t              tbl_q [c_entries];

    logic                 busy, sweep_we, run, predict;
    logic                 x0_eff, x1_eff, same_idx, any_misp;
    logic [TBL_BITS-1:0]  fetch_idx, upd0_idx, upd1_idx;
    bp_ctr_t              ctr0_old, ctr0_new, ctr1_old, ctr1_new;
    logic                 we0, we1;
    logic [TBL_BITS-1:0]  wa0, wa1;
    bp_ctr_t              wd0, wd1;

    // Address bits outside the index window are intentionally ignored.
    logic unused_ip_bits;
    assign unused_ip_bits = ^{bp.ip, bp.x0_ip, bp.x1_ip};

    // ---------------- init-sweep FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_init;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // ---------------- init-sweep FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            c_st_init: begin
                sweep_d = sweep_q + TBL_BITS'(1);
                if (sweep_q == '1) state_d = c_st_run;
            end
            default: state_d = c_st_run;
        endcase
    end

    // ---------------- init-sweep FSM: outputs ----------------
    always_comb begin
        busy     = (state_q == c_st_init);
        sweep_we = (state_q == c_st_init);
    end

    assign run = bp.en & ~busy;

    // ---------------- commit slot qualification and history ----------------
    // A taken or mispredicted slot 0 redirects the pipe, so slot 1 is on the
    // wrong path and must not train the table or history.
    assign x0_eff = run & bp.x0_valid;
    assign x1_eff = run & bp.x1_valid
                  & ~(bp.x0_valid & (bp.x0_takb | bp.x0_mispredict));

    assign ghist_arch_mid = x0_eff ? HIST_BITS'({ghist_arch_q, bp.x0_takb}) : ghist_arch_q;
    assign ghist_arch_d   = x1_eff ? HIST_BITS'({ghist_arch_mid, bp.x1_takb}) : ghist_arch_mid;

    // ---------------- index hashing ----------------
    generate
        if (MODE == 0) begin : g_gselect
            assign fetch_idx = {bp.ip[TBL_BITS-HIST_BITS:1], ghist_spec_q};
            assign upd0_idx  = {bp.x0_ip[TBL_BITS-HIST_BITS:1], ghist_arch_q};
            assign upd1_idx  = {bp.x1_ip[TBL_BITS-HIST_BITS:1], ghist_arch_mid};
        end else begin : g_gshare
            assign fetch_idx = bp.ip[TBL_BITS:1] ^ TBL_BITS'(ghist_spec_q);
            assign upd0_idx  = bp.x0_ip[TBL_BITS:1] ^ TBL_BITS'(ghist_arch_q);
            assign upd1_idx  = bp.x1_ip[TBL_BITS:1] ^ TBL_BITS'(ghist_arch_mid);
        end
    endgenerate

    // ---------------- prediction (async read, read-old on collision) ----------------
    assign predict          = tbl_q[fetch_idx][1] & run;
    assign bp.predict_taken = predict;
    assign bp.busy          = busy;
    assign bp.ghist_spec_o  = ghist_spec_q;

    // ---------------- counter updates, slot 1 chained onto slot 0 ----------------
    assign same_idx = x0_eff & (upd1_idx == upd0_idx);
    assign ctr0_old = tbl_q[upd0_idx];
    assign ctr1_old = same_idx ? ctr0_new : tbl_q[upd1_idx];

    thor2022_bp_ctr_update u_upd0 (.i_ctr(ctr0_old), .i_takb(bp.x0_takb), .o_ctr(ctr0_new));
    thor2022_bp_ctr_update u_upd1 (.i_ctr(ctr1_old), .i_takb(bp.x1_takb), .o_ctr(ctr1_new));

    // Port 0 carries the init sweep or slot 0. When both slots hit the same
    // entry only port 1 writes, carrying the chained result, so there is a
    // single write. Port 1 is only used by an effective slot 1.
    always_comb begin
        if (sweep_we) begin
            we0 = 1'b1;
            wa0 = sweep_q;
            wd0 = INIT_CTR;
        end else begin
            we0 = x0_eff & ~(x1_eff & same_idx);
            wa0 = upd0_idx;
            wd0 = ctr0_new;
        end
        we1 = x1_eff;
        wa1 = upd1_idx;
        wd1 = ctr1_new;
    end

    always_ff @(posedge clk) begin
        if (we0) tbl_q[wa0] <= wd0;
        if (we1) tbl_q[wa1] <= wd1;
    end

    // ---------------- speculative history ----------------
    // A mispredict reloads the committed history including the actual
    // outcome, overriding any fetch-side shift in the same cycle.
    assign any_misp = (x0_eff & bp.x0_mispredict) | (x1_eff & bp.x1_mispredict);

    always_comb begin
        ghist_spec_d = ghist_spec_q;
        if (run & bp.ibranch) ghist_spec_d = HIST_BITS'({ghist_spec_q, predict});
        if (any_misp)         ghist_spec_d = ghist_arch_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghist_spec_q <= '0;
            ghist_arch_q <= '0;
        end else begin
            ghist_spec_q <= ghist_spec_d;
            ghist_arch_q <= ghist_arch_d;
        end
    end

endmodule
`default_nettype wire
